net2axis_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter: merges C_NUM_SLAVES AXI-Stream sources
//  (e.g. several net2axis_master instances) onto one AXI-Stream master port

---
 rtl/net2axis_arbiter.sv | 152 +++++++++++++++
 tb/tb_net2axis_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net2axis_arbiter.sv
// net2axis_arbiter
// Packet-granular round-robin merge of C_NUM_SLAVES AXI-Stream inputs onto one
// registered AXI-Stream output. A grant is held from the first beat up to and
// including TLAST, so packets from different inputs never interleave.
module net2axis_arbiter #(
    parameter int C_TDATA_WIDTH = 32,
    parameter int C_NUM_SLAVES  = 4,
    parameter int C_IDX_WIDTH   = 2
) (
    input  logic                                      ACLK,
    input  logic                                      ARESETN,
    input  logic [C_NUM_SLAVES-1:0]                   S_AXIS_TVALID,
    input  logic [C_NUM_SLAVES*C_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_NUM_SLAVES*C_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
    input  logic [C_NUM_SLAVES-1:0]                   S_AXIS_TLAST,
    output logic [C_NUM_SLAVES-1:0]                   S_AXIS_TREADY,
    output logic                                      M_AXIS_TVALID,
    output logic [C_TDATA_WIDTH-1:0]                  M_AXIS_TDATA,
    output logic [C_TDATA_WIDTH/8-1:0]                M_AXIS_TKEEP,
    output logic                                      M_AXIS_TLAST,
    input  logic                                      M_AXIS_TREADY,
    output logic [C_IDX_WIDTH-1:0]                    GRANT_IDX,
    output logic                                      BUSY,
    output logic [31:0]                               PKT_COUNT
);

    localparam int          W  = C_TDATA_WIDTH;
    localparam int          KW = C_TDATA_WIDTH / 8;
    localparam int unsigned NU = C_NUM_SLAVES;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_nxt;
    logic [C_IDX_WIDTH-1:0] grant_q;
    logic [C_IDX_WIDTH-1:0] grant_nxt;

    logic                   arb_found;
    logic [C_IDX_WIDTH-1:0] arb_idx;
    logic [C_IDX_WIDTH-1:0] cand;

    logic                   sel_valid;
    logic [W-1:0]           sel_data;
    logic [KW-1:0]          sel_keep;
    logic                   sel_last;
    logic                   sel_ready;
    logic                   s_fire;

    logic [31:0]            pkt_cnt;

    // Round-robin search starting just after the last granted input
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = grant_q;
        cand      = '0;
        for (int unsigned k = 1; k <= NU; k++) begin
            cand = C_IDX_WIDTH'((32'(grant_q) + k) % NU);
            if (!arb_found && S_AXIS_TVALID[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Mux the granted input lane and form its handshake
    always_comb begin
        sel_valid = S_AXIS_TVALID[grant_q];
        sel_data  = S_AXIS_TDATA[32'(grant_q) * W +: W];
        sel_keep  = S_AXIS_TKEEP[32'(grant_q) * KW +: KW];
        sel_last  = S_AXIS_TLAST[grant_q];
        // Only M_AXIS_TREADY reaches S_AXIS_TREADY combinationally
        sel_ready = (state_q == ST_BUSY) && (!M_AXIS_TVALID || M_AXIS_TREADY);
        s_fire    = sel_ready && sel_valid;
    end

    // Per-input ready: only the granted input sees the output slot state
    always_comb begin
        S_AXIS_TREADY          = '0;
        S_AXIS_TREADY[grant_q] = sel_ready;
    end

    // Next-state: IDLE spends one cycle arbitrating, BUSY ends on accepted TLAST
    always_comb begin
        state_nxt = state_q;
        grant_nxt = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_nxt = arb_idx;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_fire && sel_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and grant registers; grant resets to N-1 so input 0 wins first
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            grant_q <= C_IDX_WIDTH'(C_NUM_SLAVES - 1);
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
        end
    end

    // Output register: loads on an accepted beat, empties when the sink takes it
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TKEEP  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (s_fire) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= sel_data;
            M_AXIS_TKEEP  <= sel_keep;
            M_AXIS_TLAST  <= sel_last;
        end else if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
        end
    end

    // Packet counter, bumped on each output TLAST handshake, free-running wrap
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pkt_cnt <= '0;
        end else if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
            pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

    // Status outputs
    always_comb begin
        GRANT_IDX = grant_q;
        BUSY      = (state_q == ST_BUSY);
        PKT_COUNT = pkt_cnt;
    end

endmodule

// File: tb/tb_net2axis_arbiter.sv
// Testbench for net2axis_arbiter (N=4, 32-bit data).
// Source queues feed the inputs; an expected-beat queue is filled in predicted
// arbitration order and checked against every output handshake.
module tb_net2axis_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int KW = W / 8;

    logic              ACLK;
    logic              ARESETN;
    logic [N-1:0]      S_AXIS_TVALID;
    logic [N*W-1:0]    S_AXIS_TDATA;
    logic [N*KW-1:0]   S_AXIS_TKEEP;
    logic [N-1:0]      S_AXIS_TLAST;
    logic [N-1:0]      S_AXIS_TREADY;
    logic              M_AXIS_TVALID;
    logic [W-1:0]      M_AXIS_TDATA;
    logic [KW-1:0]     M_AXIS_TKEEP;
    logic              M_AXIS_TLAST;
    logic              M_AXIS_TREADY;
    logic [1:0]        GRANT_IDX;
    logic              BUSY;
    logic [31:0]       PKT_COUNT;

    net2axis_arbiter #(
        .C_TDATA_WIDTH(W),
        .C_NUM_SLAVES (N),
        .C_IDX_WIDTH  (2)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TDATA (S_AXIS_TDATA),
        .S_AXIS_TKEEP (S_AXIS_TKEEP),
        .S_AXIS_TLAST (S_AXIS_TLAST),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TKEEP (M_AXIS_TKEEP),
        .M_AXIS_TLAST (M_AXIS_TLAST),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .GRANT_IDX    (GRANT_IDX),
        .BUSY         (BUSY),
        .PKT_COUNT    (PKT_COUNT)
    );

    typedef struct packed {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t src_q[N][$];
    beat_t exp_q[$];
    bit    rdy_pat[$];

    int    errors    = 0;
    int    checks    = 0;
    int    cyc       = 0;
    int    out_beats = 0;
    bit    gap_chk   = 0;
    bit    have_prev = 0;
    bit    prev_last = 0;
    int    last_cyc  = 0;
    int    pkt_exp   = 0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic beat_t make_beat(input int src, input int pkt, input int b, input int n);
        beat_t x;
        x.data = {8'(src), 8'(pkt), 8'(b), 8'hA5};
        x.last = (b == n - 1);
        x.keep = x.last ? (4'hF >> src) : 4'hF;
        return x;
    endfunction

    task automatic push_src(input int src, input int pkt, input int n);
        for (int b = 0; b < n; b++) src_q[src].push_back(make_beat(src, pkt, b, n));
    endtask

    task automatic push_exp(input int src, input int pkt, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back(make_beat(src, pkt, b, n));
        pkt_exp++;
    endtask

    function automatic bit src_pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() > 0 || src_pending()) && n < 2000) begin
            @(posedge ACLK);
            n++;
        end
        checks++;
        assert (n < 2000) else begin
            errors++;
            $error("FAIL %s_timeout: observed=%0d cycles expected<2000", tag, n);
        end
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
    endtask

    // Source driver: pops a beat after its handshake, presents the next head
    initial begin
        logic [N-1:0] fired;
        S_AXIS_TVALID = '0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TLAST  = '0;
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(negedge ACLK);
            fired = S_AXIS_TVALID & S_AXIS_TREADY;
            @(posedge ACLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    S_AXIS_TVALID[i]          = 1'b1;
                    S_AXIS_TDATA[i*W +: W]    = src_q[i][0].data;
                    S_AXIS_TKEEP[i*KW +: KW]  = src_q[i][0].keep;
                    S_AXIS_TLAST[i]           = src_q[i][0].last;
                end else begin
                    S_AXIS_TVALID[i]          = 1'b0;
                    S_AXIS_TDATA[i*W +: W]    = '0;
                    S_AXIS_TKEEP[i*KW +: KW]  = '0;
                    S_AXIS_TLAST[i]           = 1'b0;
                end
            end
            M_AXIS_TREADY = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        end
    end

    // Output monitor: scoreboard compare, stall stability, beat spacing
    initial begin
        bit    hold_prev = 0;
        beat_t hold_val;
        beat_t e;
        forever begin
            @(negedge ACLK);
            if (ARESETN) begin
                if (hold_prev && M_AXIS_TVALID)
                    chk("hold_stable", {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST}, hold_val);
                if (M_AXIS_TVALID && !M_AXIS_TREADY) begin
                    chk("stall_s_tready", S_AXIS_TREADY, 0);
                    hold_prev = 1;
                    hold_val  = {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST};
                end else begin
                    hold_prev = 0;
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_beat: observed=%0h expected=none", M_AXIS_TDATA);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_beat", {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST}, e);
                    end
                    if (gap_chk && have_prev)
                        chk("beat_gap", cyc - last_cyc, prev_last ? 2 : 1);
                    have_prev = 1;
                    prev_last = M_AXIS_TLAST;
                    last_cyc  = cyc;
                    out_beats++;
                end
            end else begin
                hold_prev = 0;
            end
        end
    end

    initial begin
        int base;
        int n;

        // Reset state
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_m_tvalid", M_AXIS_TVALID, 0);
        chk("rst_m_tdata", M_AXIS_TDATA, 0);
        chk("rst_s_tready", S_AXIS_TREADY, 0);
        chk("rst_grant", GRANT_IDX, 3);
        chk("rst_busy", BUSY, 0);
        chk("rst_pkt_count", PKT_COUNT, 0);
        ARESETN = 1'b1;

        // Single requester on input 2: re-granted for each packet
        gap_chk   = 1;
        have_prev = 0;
        push_src(2, 0, 3); push_src(2, 1, 2);
        push_exp(2, 0, 3); push_exp(2, 1, 2);
        drain("t1");
        chk("t1_grant", GRANT_IDX, 2);
        chk("t1_pkt_count", PKT_COUNT, pkt_exp);
        chk("t1_busy", BUSY, 0);

        // All inputs requesting: strict rotation starting after input 2
        have_prev = 0;
        for (int s = 0; s < N; s++) begin
            push_src(s, 0, 2);
            push_src(s, 1, 2);
        end
        for (int p = 0; p < 2; p++) begin
            push_exp(3, p, 2);
            push_exp(0, p, 2);
            push_exp(1, p, 2);
            push_exp(2, p, 2);
        end
        drain("t2");
        chk("t2_grant", GRANT_IDX, 2);
        chk("t2_pkt_count", PKT_COUNT, pkt_exp);
        gap_chk = 0;

        // Sink backpressure mid-packet
        for (int i = 0; i < 9; i++) rdy_pat.push_back((i == 3 || i == 4 || i == 6 || i == 7) ? 1'b0 : 1'b1);
        push_src(0, 5, 4);
        push_exp(0, 5, 4);
        drain("t3");
        chk("t3_grant", GRANT_IDX, 0);
        chk("t3_pkt_count", PKT_COUNT, pkt_exp);

        // Asynchronous reset in the middle of a packet from input 1
        base = out_beats;
        push_src(1, 6, 4);
        push_exp(1, 6, 4);
        n = 0;
        while (out_beats < base + 1 && n < 200) begin
            @(posedge ACLK);
            n++;
        end
        checks++;
        assert (n < 200) else begin
            errors++;
            $error("FAIL t4_wait_timeout: observed=%0d cycles expected<200", n);
        end
        @(posedge ACLK);
        #3;
        ARESETN = 1'b0;
        #1;
        chk("t4_m_tvalid", M_AXIS_TVALID, 0);
        chk("t4_m_tlast", M_AXIS_TLAST, 0);
        chk("t4_m_tdata", M_AXIS_TDATA, 0);
        chk("t4_m_tkeep", M_AXIS_TKEEP, 0);
        chk("t4_s_tready", S_AXIS_TREADY, 0);
        chk("t4_grant", GRANT_IDX, 3);
        chk("t4_busy", BUSY, 0);
        chk("t4_pkt_count", PKT_COUNT, 0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        rdy_pat.delete();
        pkt_exp = 0;
        repeat (2) @(posedge ACLK);
        push_src(1, 7, 2);
        push_src(0, 7, 3);
        push_exp(0, 7, 3);
        push_exp(1, 7, 2);
        @(negedge ACLK);
        ARESETN = 1'b1;
        drain("t4");
        chk("t4_after_grant", GRANT_IDX, 1);
        chk("t4_after_pkt_count", PKT_COUNT, pkt_exp);

        // Packet counter wrap from all-ones
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        @(negedge ACLK);
        release dut.pkt_cnt;
        @(negedge ACLK);
        chk("t5_preload", PKT_COUNT, 32'hFFFF_FFFF);
        push_src(2, 8, 1);
        push_exp(2, 8, 1);
        drain("t5");
        chk("t5_wrap", PKT_COUNT, 0);
        chk("t5_grant", GRANT_IDX, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: observed=time limit expected=completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit reached");
    end

endmodule
